// File: rtl/shifter_pkg.sv
//------------------------------------------------------------------------------
// shifter_pkg : opcode enum and decode helper for pipelined_shifter.
// Rotates are decoded only when SHIFTER_ROTATE_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SRL = 3'b000,
    OP_SLL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROR = 3'b100,
    OP_ROL = 3'b101
  } shift_op_e;

  typedef struct packed {
    logic left;
    logic arith;
    logic rotate;
  } shift_ctl_t;

  function automatic shift_ctl_t decode_op(input logic [2:0] op);
    shift_ctl_t c;
    c.left  = op[0];
    c.arith = (op == 3'b010);
`ifdef SHIFTER_ROTATE_EN
    c.rotate = op[2];
`else
    c.rotate = 1'b0;
`endif
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_level.sv
//------------------------------------------------------------------------------
// shift_level : one right-shift mux level of fixed amount AMT.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic             fill_i,
  input  logic             rotate_i,
  output logic [WIDTH-1:0] data_o
);

`ifdef SHIFTER_ROTATE_EN
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      if (rotate_i) data_o = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
      else          data_o = {{AMT{fill_i}}, data_i[WIDTH-1:AMT]};
    end
  end
`else
  logic unused_rotate;
  assign unused_rotate = rotate_i;

  always_comb begin
    data_o = data_i;
    if (en_i) data_o = {{AMT{fill_i}}, data_i[WIDTH-1:AMT]};
  end
`endif

endmodule

`default_nettype wire

// File: rtl/pipelined_shifter.sv
//------------------------------------------------------------------------------
// pipelined_shifter : valid/ready barrel shifter, log2(WIDTH) levels spread over
// PIPE_STAGES registers. ROR/ROL built only with SHIFTER_ROTATE_EN. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SW = $clog2(WIDTH);
  localparam int NL = SW;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    shamt;
    shift_ctl_t       ctl;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // First level index owned by stage s; earlier stages take the remainder.
  function automatic int stage_first(input int s);
    return s * (NL / PIPE_STAGES) + ((s < NL % PIPE_STAGES) ? s : NL % PIPE_STAGES);
  endfunction

  function automatic int stage_of(input int j);
    int r;
    r = 0;
    for (int s = 1; s < PIPE_STAGES; s++) if (stage_first(s) <= j) r = s;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  stage_t                 stage_q   [PIPE_STAGES];
  stage_t                 stage_d   [PIPE_STAGES];
  stage_t                 stage_cap [PIPE_STAGES];
  logic [PIPE_STAGES:0]   adv;
  logic [PIPE_STAGES:0]   vchain;
  shift_ctl_t             in_ctl;
  stage_t                 in_payload;

  assign in_ctl     = decode_op(in_op);
  assign in_payload = {(in_ctl.left ? rev(in_data) : in_data), in_shamt, in_ctl, in_tag};

  always_comb begin
    adv              = '0;
    adv[PIPE_STAGES] = out_ready;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) adv[s] = ~valid_q[s] | adv[s+1];
  end

  // Flush also withholds in_ready so a killed offer is never seen as accepted.
  assign in_ready = adv[0] & ~flush;

  for (genvar j = 0; j < NL; j++) begin : g_level
    stage_t           lvl_in;
    stage_t           lvl_out;
    logic [WIDTH-1:0] lvl_data;

    if (j == 0) begin : g_src_in
      assign lvl_in = in_payload;
    end else if (stage_first(stage_of(j)) == j) begin : g_src_reg
      assign lvl_in = stage_q[stage_of(j) - 1];
    end else begin : g_src_chain
      assign lvl_in = g_level[j-1].lvl_out;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .AMT   (WIDTH >> (j + 1))
    ) u_level (
      .data_i   (lvl_in.data),
      .en_i     (lvl_in.shamt[SW-1-j]),
      .fill_i   (lvl_in.ctl.arith & lvl_in.data[WIDTH-1]),
      .rotate_i (lvl_in.ctl.rotate),
      .data_o   (lvl_data)
    );

    assign lvl_out = {lvl_data, lvl_in.shamt, lvl_in.ctl, lvl_in.tag};

    if (stage_first(stage_of(j) + 1) - 1 == j) begin : g_cap
      assign stage_cap[stage_of(j)] = lvl_out;
    end
  end

  assign vchain = {valid_q, in_valid};

  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (adv[s]) begin
          valid_d[s] = vchain[s];
          stage_d[s] = stage_cap[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) stage_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_data  = stage_q[PIPE_STAGES-1].ctl.left ? rev(stage_q[PIPE_STAGES-1].data)
                                                      : stage_q[PIPE_STAGES-1].data;
  assign out_tag   = stage_q[PIPE_STAGES-1].tag;

  // Consumed shamt bits and last-stage decode bits are carried but never read.
  logic unused_bits;
  always_comb begin
    unused_bits = stage_q[PIPE_STAGES-1].ctl.arith ^ stage_q[PIPE_STAGES-1].ctl.rotate;
    for (int s = 0; s < PIPE_STAGES; s++) unused_bits = unused_bits ^ (^stage_q[s].shamt);
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
//------------------------------------------------------------------------------
// tb_pipelined_shifter : directed bench over WIDTH/PIPE_STAGES = 32/2, 64/1, 64/6.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid_v  [N];
  logic        in_ready_v  [N];
  logic [2:0]  in_op_v     [N];
  logic [5:0]  in_shamt_v  [N];
  logic [63:0] in_data_v   [N];
  logic [5:0]  in_tag_v    [N];
  logic        out_valid_v [N];
  logic        out_ready_v [N];
  logic [63:0] out_data_v  [N];
  logic [5:0]  out_tag_v   [N];
  logic [31:0] out_data0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign out_data_v[0] = {32'h0, out_data0};

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(6)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_op(in_op_v[0]),
    .in_shamt(in_shamt_v[0][4:0]), .in_data(in_data_v[0][31:0]), .in_tag(in_tag_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data0), .out_tag(out_tag_v[0])
  );

  pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_op(in_op_v[1]),
    .in_shamt(in_shamt_v[1]), .in_data(in_data_v[1]), .in_tag(in_tag_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_v[1]), .out_tag(out_tag_v[1])
  );

  pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(6), .TAG_W(6)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_op(in_op_v[2]),
    .in_shamt(in_shamt_v[2]), .in_data(in_data_v[2]), .in_tag(in_tag_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_data(out_data_v[2]), .out_tag(out_tag_v[2])
  );

`ifdef SHIFTER_ROTATE_EN
  localparam logic [31:0] E_ROR32 = 32'h8000_0000;
  localparam logic [63:0] E_ROR64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] E_ROL32 = 32'h0000_0018;
  localparam logic [63:0] E_ROL64 = 64'h0000_0000_0000_0018;
  localparam logic [31:0] E_O6_32 = 32'hAB00_0000;
  localparam logic [63:0] E_O6_64 = 64'hAB00_0000_0000_0000;
  localparam logic [31:0] E_O7_32 = 32'h0000_00FF;
  localparam logic [63:0] E_O7_64 = 64'h0000_0000_0000_00FF;
`else
  localparam logic [31:0] E_ROR32 = 32'h0000_0000;
  localparam logic [63:0] E_ROR64 = 64'h0000_0000_0000_0000;
  localparam logic [31:0] E_ROL32 = 32'h0000_0010;
  localparam logic [63:0] E_ROL64 = 64'h0000_0000_0000_0010;
  localparam logic [31:0] E_O6_32 = 32'h0000_0000;
  localparam logic [63:0] E_O6_64 = 64'h0000_0000_0000_0000;
  localparam logic [31:0] E_O7_32 = 32'h0000_00F0;
  localparam logic [63:0] E_O7_64 = 64'h0000_0000_0000_00F0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  sh32;
    logic [31:0] d32;
    logic [31:0] e32;
    logic [5:0]  sh64;
    logic [63:0] d64;
    logic [63:0] e64;
  } vec_t;

  vec_t vecs [$];

  function automatic int ps_of(input int id);
    case (id)
      0:       return 2;
      1:       return 1;
      default: return 6;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int id, input logic v, input logic [2:0] op, input logic [5:0] sh,
                        input logic [63:0] d, input logic [5:0] tag);
    in_valid_v[id] = v;
    in_op_v[id]    = op;
    in_shamt_v[id] = sh;
    in_data_v[id]  = d;
    in_tag_v[id]   = tag;
  endtask

  // Single operation on an otherwise empty pipe; checks latency, data and tag.
  task automatic send_one(input int id, input string name, input logic [2:0] op,
                          input logic [5:0] sh, input logic [63:0] d, input logic [5:0] tag,
                          input logic [63:0] exp);
    int w;
    int lat;
    set_in(id, 1'b1, op, sh, d, tag);
    out_ready_v[id] = 1'b1;
    #1;
    w = 0;
    while (!in_ready_v[id] && w < 20) begin tick(); w++; end
    tick();
    in_valid_v[id] = 1'b0;
    lat = 0;
    while (!out_valid_v[id] && lat < 20) begin tick(); lat++; end
    check({name, "_lat"}, 64'(lat), 64'(ps_of(id) - 1));
    check({name, "_data"}, out_data_v[id], exp);
    check({name, "_tag"}, {58'h0, out_tag_v[id]}, {58'h0, tag});
    tick();
  endtask

  task automatic stream(input int id);
    int ps, sent, rx, occ, stall_left;
    bit stall_done, was_stalled;
    logic [63:0] hd;
    logic [5:0]  ht;
    logic acc, emit;
    ps = ps_of(id); sent = 0; rx = 0; occ = 0; stall_left = 0;
    stall_done = 1'b0; was_stalled = 1'b0; hd = '0; ht = '0;
    for (int cyc = 0; cyc < 80 && rx < 6; cyc++) begin
      if (rx >= 2 && !stall_done) begin stall_left = 3; stall_done = 1'b1; end
      out_ready_v[id] = (stall_left == 0);
      set_in(id, sent < 6, OP_SLL, 6'(sent + 1), 64'd3, 6'(sent + 1));
      #1;
      check($sformatf("str%0d_in_ready", id), {63'h0, in_ready_v[id]},
            {63'h0, !(occ == ps && !out_ready_v[id])});
      if (was_stalled) begin
        check($sformatf("str%0d_hold_v", id), {63'h0, out_valid_v[id]}, 64'd1);
        check($sformatf("str%0d_hold_d", id), out_data_v[id], hd);
        check($sformatf("str%0d_hold_t", id), {58'h0, out_tag_v[id]}, {58'h0, ht});
      end
      acc  = in_valid_v[id] & in_ready_v[id];
      emit = out_valid_v[id] & out_ready_v[id];
      if (emit) begin
        check($sformatf("str%0d_d%0d", id, rx + 1), out_data_v[id], 64'd3 << (rx + 1));
        check($sformatf("str%0d_t%0d", id, rx + 1), {58'h0, out_tag_v[id]}, 64'(rx + 1));
        rx++;
      end
      was_stalled = out_valid_v[id] & ~out_ready_v[id];
      hd = out_data_v[id];
      ht = out_tag_v[id];
      if (stall_left > 0) stall_left--;
      occ = occ + int'(acc) - int'(emit);
      if (acc) sent++;
      tick();
    end
    in_valid_v[id]  = 1'b0;
    out_ready_v[id] = 1'b1;
    check($sformatf("str%0d_count", id), 64'(rx), 64'd6);
  endtask

  // Fills n stages with out_ready low, then applies flush (kill=1) or rst (kill=0).
  task automatic kill_test(input int id, input bit use_flush, input int n);
    int seen;
    out_ready_v[id] = 1'b0;
    for (int k = 0; k < n; k++) begin
      set_in(id, 1'b1, OP_SLL, 6'd1, 64'd5, 6'(40 + k));
      tick();
    end
    set_in(id, 1'b1, OP_SLL, 6'd1, 64'd5, 6'd50);
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    tick();
    in_valid_v[id] = 1'b0;
    if (use_flush) begin
      flush = 1'b0;
      check($sformatf("flush%0d_ov", id), {63'h0, out_valid_v[id]}, 64'd0);
    end else begin
      check($sformatf("rst%0d_ov", id), {63'h0, out_valid_v[id]}, 64'd0);
      check($sformatf("rst%0d_od", id), out_data_v[id], 64'd0);
      check($sformatf("rst%0d_ot", id), {58'h0, out_tag_v[id]}, 64'd0);
      check($sformatf("rst%0d_ir", id), {63'h0, in_ready_v[id]}, 64'd1);
      rst = 1'b0;
    end
    out_ready_v[id] = 1'b1;
    seen = 0;
    repeat (10) begin
      if (out_valid_v[id]) seen++;
      tick();
    end
    check($sformatf("%s%0d_none", use_flush ? "flush" : "rst", id), 64'(seen), 64'd0);
    send_one(id, $sformatf("post_kill%0d", id), OP_SRL, 6'd1, 64'h10, 6'd33, 64'h8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_in(i, 1'b0, 3'b000, 6'd0, 64'd0, 6'd0);
      out_ready_v[i] = 1'b1;
    end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset%0d_ov", i), {63'h0, out_valid_v[i]}, 64'd0);
      check($sformatf("reset%0d_od", i), out_data_v[i], 64'd0);
      check($sformatf("reset%0d_ot", i), {58'h0, out_tag_v[i]}, 64'd0);
      check($sformatf("reset%0d_ir", i), {63'h0, in_ready_v[i]}, 64'd1);
    end
    tick();

    vecs.push_back('{3'b000, 6'd4,  32'h8000_0000, 32'h0800_0000, 6'd4,  64'h8000_0000_0000_0000, 64'h0800_0000_0000_0000});
    vecs.push_back('{3'b010, 6'd4,  32'h8000_0000, 32'hF800_0000, 6'd4,  64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000});
    vecs.push_back('{3'b001, 6'd31, 32'h0000_0001, 32'h8000_0000, 6'd63, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000});
    vecs.push_back('{3'b010, 6'd3,  32'h4000_0000, 32'h0800_0000, 6'd3,  64'h4000_0000_0000_0000, 64'h0800_0000_0000_0000});
    vecs.push_back('{3'b011, 6'd8,  32'h0000_00F0, 32'h0000_F000, 6'd8,  64'h0000_0000_0000_00F0, 64'h0000_0000_0000_F000});
    vecs.push_back('{3'b010, 6'd31, 32'hF000_0000, 32'hFFFF_FFFF, 6'd63, 64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{3'b001, 6'd16, 32'h0000_ABCD, 32'hABCD_0000, 6'd32, 64'h0000_0000_0000_ABCD, 64'h0000_ABCD_0000_0000});
    vecs.push_back('{3'b000, 6'd17, 32'hFFFF_0000, 32'h0000_7FFF, 6'd33, 64'hFFFF_0000_0000_0000, 64'h0000_0000_7FFF_8000});
    vecs.push_back('{3'b100, 6'd1,  32'h0000_0001, E_ROR32,       6'd1,  64'h0000_0000_0000_0001, E_ROR64});
    vecs.push_back('{3'b101, 6'd4,  32'h8000_0001, E_ROL32,       6'd4,  64'h8000_0000_0000_0001, E_ROL64});
    vecs.push_back('{3'b110, 6'd8,  32'h0000_00AB, E_O6_32,       6'd8,  64'h0000_0000_0000_00AB, E_O6_64});
    vecs.push_back('{3'b111, 6'd4,  32'hF000_000F, E_O7_32,       6'd4,  64'hF000_0000_0000_000F, E_O7_64});

    foreach (vecs[k]) begin
      send_one(0, $sformatf("vec%0d_w32", k), vecs[k].op, vecs[k].sh32,
               {32'h0, vecs[k].d32}, 6'(k), {32'h0, vecs[k].e32});
      for (int id = 1; id < N; id++)
        send_one(id, $sformatf("vec%0d_d%0d", k, id), vecs[k].op, vecs[k].sh64,
                 vecs[k].d64, 6'(k), vecs[k].e64);
    end

    for (int op = 0; op < 8; op++) begin
      send_one(0, $sformatf("sh0_op%0d_w32", op), 3'(op), 6'd0,
               64'h0000_0000_DEAD_BEEF, 6'(op + 16), 64'h0000_0000_DEAD_BEEF);
      for (int id = 1; id < N; id++)
        send_one(id, $sformatf("sh0_op%0d_d%0d", op, id), 3'(op), 6'd0,
                 64'hDEAD_BEEF_CAFE_F00D, 6'(op + 16), 64'hDEAD_BEEF_CAFE_F00D);
    end

    for (int id = 0; id < N; id++) begin
      stream(id);
      repeat (3) tick();
      kill_test(id, 1'b1, (ps_of(id) >= 2) ? 2 : 1);
      kill_test(id, 1'b0, ps_of(id));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
